// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the multicycle control FSM and the HI/LO
// multiply/divide unit. The control FSM drives the master side.
`timescale 1ns/1ps

interface mult_div_unit_if;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start_mult, start_div, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed 32x32 Booth multiplier / 32/32 restoring divider producing HI/LO.
// Optional fast divide-by-zero exit is enabled with `define MULTDIV_DIVZERO_CHECK_EN.
`timescale 1ns/1ps

module mult_div_unit (
    input  logic            clock,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_cnt;
    logic [64:0] r_booth;   // {acc, multiplier, q-1}
    logic [31:0] r_mcand;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_dz;

    logic        w_accept;
    logic        w_go_mult;
    logic        w_go_div;
    logic        w_dz_fast;
    logic        w_last;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_acc_ext;
    logic [32:0] w_mc_ext;
    logic [32:0] w_sum;
    logic [64:0] w_booth_nxt;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    // New work is only accepted when idle or in the completion cycle; multiply wins ties.
    assign w_accept  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_go_mult = w_accept & bus.start_mult;
    assign w_go_div  = w_accept & ~bus.start_mult & bus.start_div;
    assign w_last    = (r_cnt == 5'd31);

`ifdef MULTDIV_DIVZERO_CHECK_EN
    assign w_dz_fast = w_go_div & (bus.b == 32'd0);
`else
    assign w_dz_fast = 1'b0;
`endif

    assign w_abs_a = bus.a[31] ? (32'd0 - bus.a) : bus.a;
    assign w_abs_b = bus.b[31] ? (32'd0 - bus.b) : bus.b;

    // Booth add is done one bit wider so subtracting -2^31 cannot overflow the accumulator.
    assign w_acc_ext = {r_booth[64], r_booth[64:33]};
    assign w_mc_ext  = {r_mcand[31], r_mcand};

    always_comb begin
        w_sum = w_acc_ext;
        case (r_booth[1:0])
            2'b01:   w_sum = w_acc_ext + w_mc_ext;
            2'b10:   w_sum = w_acc_ext - w_mc_ext;
            default: w_sum = w_acc_ext;
        endcase
    end

    assign w_booth_nxt = {w_sum, r_booth[32:1]};

    // Restoring step: shift in the next dividend bit, subtract when it fits.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_diff    = w_shift[31:0] - r_dvs;
    assign w_rem_nxt = w_ge ? w_diff : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_ge};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_go_mult)
                    w_next = S_MULT;
                else if (w_go_div)
                    w_next = w_dz_fast ? S_DONE : S_DIV;
                else
                    w_next = S_IDLE;
            end
            S_MULT:  if (w_last) w_next = S_DONE;
            S_DIV:   if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= 5'd0;
            r_booth <= 65'd0;
            r_mcand <= 32'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_dvs   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= (w_next == S_DONE);
            r_dz   <= w_dz_fast;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go_mult) begin
                        r_booth <= {32'd0, bus.a, 1'b0};
                        r_mcand <= bus.b;
                        r_cnt   <= 5'd0;
                    end else if (w_go_div && !w_dz_fast) begin
                        r_rem   <= 32'd0;
                        r_quo   <= w_abs_a;
                        r_dvs   <= w_abs_b;
                        r_neg_q <= bus.a[31] ^ bus.b[31];
                        r_neg_r <= bus.a[31];
                        r_cnt   <= 5'd0;
                    end
                end
                S_MULT: begin
                    r_booth <= w_booth_nxt;
                    r_cnt   <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_hi <= w_booth_nxt[64:33];
                        r_lo <= w_booth_nxt[32:1];
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    // Truncating division: remainder follows the dividend's sign.
                    r_hi <= r_neg_r ? (32'd0 - r_rem) : r_rem;
                    r_lo <= r_neg_q ? (32'd0 - r_quo) : r_quo;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.busy     = (r_state == S_MULT) || (r_state == S_DIV) || (r_state == S_FIX);
    assign bus.done     = r_done;
    assign bus.div_zero = r_dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + random scoreboard bench for mult_div_unit: latency, HI/LO values,
// divide-by-zero behaviour (both macro settings), busy-start rejection and async reset.
`timescale 1ns/1ps

module tb_mult_div_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference {hi, lo} from language arithmetic; divide by zero follows the full-path result.
    function automatic logic [63:0] model(input logic m, input logic [31:0] av, input logic [31:0] bv);
        logic signed [63:0] sa, sb64, p;
        int qa, qb, q, r;
        if (m) begin
            sa   = 64'(signed'(av));
            sb64 = 64'(signed'(bv));
            p    = sa * sb64;
            return p;
        end
        if (bv == 32'd0)
            return {av, (av[31] ? 32'd1 : 32'hFFFFFFFF)};
        if (av == 32'h80000000 && bv == 32'hFFFFFFFF)
            return {32'd0, 32'h80000000};
        qa = av;
        qb = bv;
        q  = qa / qb;
        r  = qa % qb;
        return {32'(r), 32'(q)};
    endfunction

    // Called at a negedge; returns #1 after the sampling edge E0 (inside cycle 0).
    task automatic issue(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv,
                         input string tag, input int lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edz, input logic push);
        exp_t e;
        bus.start_mult = m;
        bus.start_div  = d;
        bus.a          = av;
        bus.b          = bv;
        if (push) begin
            e.tag = tag; e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = $urandom;
        bus.b          = $urandom;
    endtask

    // Waits (bounded) for done; optionally pulses start_div during cycle pulse_at.
    task automatic wait_done(input int pulse_at);
        exp_t e;
        bit   seen;
        int   n;
        seen = 1'b0;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard: observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        for (n = 0; n < 60; n++) begin
            @(negedge clock);
            if (n == 0)
                chk({e.tag, " busy_c0"}, 64'(bus.busy), 64'(e.lat != 0));
            if (n == pulse_at) begin
                bus.start_div = 1'b1;
                bus.a         = 32'd100;
                bus.b         = 32'd7;
            end else if (n == pulse_at + 1) begin
                bus.start_div = 1'b0;
            end
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({e.tag, " done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({e.tag, " latency"}, 64'(n), 64'(e.lat));
            chk({e.tag, " hi"}, 64'(bus.hi), 64'(e.hi));
            chk({e.tag, " lo"}, 64'(bus.lo), 64'(e.lo));
            chk({e.tag, " div_zero"}, 64'(bus.div_zero), 64'(e.dz));
            chk({e.tag, " busy_done"}, 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] r;
        logic [31:0] ra, rb;
        logic        rm;
        logic [31:0] hold_hi, hold_lo;
        bit          saw_done;

        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("reset hi", 64'(bus.hi), 64'd0);
        chk("reset lo", 64'(bus.lo), 64'd0);
        chk("reset flags", 64'({bus.busy, bus.done, bus.div_zero}), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Multiply 7 * -3, single done pulse
        issue(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, "mul_7x-3", 32, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);
        wait_done(-5);
        @(negedge clock);
        chk("mul_7x-3 done_once", 64'(bus.done), 64'd0);
        chk("mul_7x-3 lo_hold", 64'(bus.lo), 64'h00000000FFFFFFEB);

        // Most negative squared
        issue(1'b1, 1'b0, 32'h80000000, 32'h80000000, "mul_min2", 32, 32'h40000000, 32'h0, 1'b0, 1'b1);
        wait_done(-5);
        @(negedge clock);

        // Signed divides
        issue(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, "div_-7/2", 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
        wait_done(-5);
        @(negedge clock);
        issue(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, "div_min/-1", 33, 32'h0, 32'h80000000, 1'b0, 1'b1);
        wait_done(-5);
        @(negedge clock);

        // Divide by zero
`ifdef MULTDIV_DIVZERO_CHECK_EN
        issue(1'b0, 1'b1, 32'd5, 32'd0, "div_5/0", 0, 32'h0, 32'h80000000, 1'b1, 1'b1);
        wait_done(-5);
        @(negedge clock);
        chk("div_5/0 dz_once", 64'({bus.done, bus.div_zero}), 64'd0);
        chk("div_5/0 busy_after", 64'(bus.busy), 64'd0);
`else
        issue(1'b0, 1'b1, 32'd5, 32'd0, "div_5/0", 33, 32'd5, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_done(-5);
        @(negedge clock);
        chk("div_5/0 dz_after", 64'({bus.done, bus.div_zero}), 64'd0);
        issue(1'b0, 1'b1, 32'hFFFFFFF7, 32'd0, "div_-9/0", 33, 32'hFFFFFFF7, 32'd1, 1'b0, 1'b1);
        wait_done(-5);
        @(negedge clock);
`endif

        // start_div during a multiply is ignored; then both starts in the DONE cycle -> multiply
        r = model(1'b1, 32'd123456, 32'hFFFFFCEB);
        issue(1'b1, 1'b0, 32'd123456, 32'hFFFFFCEB, "mul_ignore_div", 32, r[63:32], r[31:0], 1'b0, 1'b1);
        wait_done(10);
        r = model(1'b1, 32'd1000, 32'hFFFFFFF6);
        issue(1'b1, 1'b1, 32'd1000, 32'hFFFFFFF6, "mul_b2b_tie", 32, r[63:32], r[31:0], 1'b0, 1'b1);
        wait_done(-5);
        @(negedge clock);

        // Reset in cycle 15 of a divide
        hold_hi  = bus.hi;
        hold_lo  = bus.lo;
        saw_done = 1'b0;
        issue(1'b0, 1'b1, 32'd1000, 32'd3, "div_reset", 33, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int n = 0; n < 15; n++) begin
            @(negedge clock);
            if (bus.done) saw_done = 1'b1;
        end
        chk("div_reset busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("div_reset async_hi", 64'(bus.hi), 64'd0);
        chk("div_reset async_lo", 64'(bus.lo), 64'd0);
        chk("div_reset async_flags", 64'({bus.busy, bus.done, bus.div_zero}), 64'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            if (bus.done) saw_done = 1'b1;
        end
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (bus.done) saw_done = 1'b1;
        end
        chk("div_reset no_done", 64'(saw_done), 64'd0);
        chk("div_reset prior_result_nonzero", 64'(hold_lo != 32'd0 || hold_hi != 32'd0), 64'd1);
        issue(1'b1, 1'b0, 32'd3, 32'd4, "mul_3x4", 32, 32'd0, 32'd12, 1'b0, 1'b1);
        wait_done(-5);
        @(negedge clock);

        // Random signed multiplies/divides against the arithmetic model
        for (int k = 0; k < 8; k++) begin
            rm = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (k == 6) rb = 32'hFFFFFFFF;
            if (!rm && rb == 32'd0) rb = 32'd1;
            if (!rm && k[0]) rb = rb >> ($urandom_range(0, 28));
            if (!rm && rb == 32'd0) rb = 32'd9;
            r = model(rm, ra, rb);
            issue(rm, ~rm, ra, rb, rm ? "rnd_mul" : "rnd_div", rm ? 32 : 33,
                  r[63:32], r[31:0], 1'b0, 1'b1);
            wait_done(-5);
            @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
